// File: rtl/seq_subtractor_if.sv
// seq_subtractor_if: request/operand and result bundle for seq_subtractor
interface seq_subtractor_if #(parameter int SIZE = 16);
  logic start, b_in, busy, done, b_out, ovf;
  logic [SIZE-1:0] input1, input2, result;
  modport master (output start, input1, input2, b_in, input busy, done, result, b_out, ovf);
  modport slave (input start, input1, input2, b_in, output busy, done, result, b_out, ovf);
endinterface

// File: rtl/seq_subtractor.sv
// seq_subtractor: chunk-serial subtractor, LSB chunk first, borrow-lookahead inside each chunk
module seq_subtractor #(
  parameter int SIZE  = 16,
  parameter int CHUNK = 4
) (
  input logic clk,
  input logic rst,
  seq_subtractor_if.slave bus
);
  localparam int N  = SIZE / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [SIZE-1:0] a_r, b_r, work, a_sh, b_sh, nxt, res_r;
  logic [CHUNK-1:0] a_c, b_c, g, p, diff;
  logic [CW-1:0] cnt;
  logic brw, c, bout, busy_r, done_r, b_out_r, ovf_r, last, ovf_nxt;
  int base;
  assign base = int'(cnt) * CHUNK;
  assign a_sh = a_r >> base;
  assign b_sh = b_r >> base;
  assign a_c = a_sh[CHUNK-1:0];
  assign b_c = b_sh[CHUNK-1:0];
  assign last = cnt == CW'(N - 1);
  // work only ever holds already-finished lower chunks, so OR-ing the new chunk in is enough
  assign nxt = work | (SIZE'(diff) << base);
  assign ovf_nxt = (a_r[SIZE-1] != b_r[SIZE-1]) & (nxt[SIZE-1] != a_r[SIZE-1]);
  // borrow-lookahead across the current chunk, seeded by the stored inter-chunk borrow
  always_comb begin
    g = ~a_c & b_c;
    p = ~(a_c ^ b_c);
    diff = '0;
    c = brw;
    for (int j = 0; j < CHUNK; j++) begin
      diff[j] = a_c[j] ^ b_c[j] ^ c;
      c = g[j] | (p[j] & c);
    end
    bout = c;
  end
  // control FSM: accept in IDLE/DONE, one chunk per RUN edge, publish results on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      work <= '0;
      res_r <= '0;
      cnt <= '0;
      brw <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      b_out_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state == RUN) begin
      brw <= bout;
      work <= nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        state <= DONE;
        busy_r <= 1'b0;
        done_r <= 1'b1;
        res_r <= nxt;
        b_out_r <= bout;
        ovf_r <= ovf_nxt;
      end
    end else begin
      done_r <= 1'b0;
      state <= bus.start ? RUN : IDLE;
      busy_r <= bus.start;
      if (bus.start) begin
        a_r <= bus.input1;
        b_r <= bus.input2;
        brw <= bus.b_in;
        work <= '0;
        cnt <= '0;
      end
    end
  end
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.result = res_r;
  assign bus.b_out = b_out_r;
  assign bus.ovf = ovf_r;
endmodule

// File: tb/tb_seq_subtractor.sv
// tb_seq_subtractor: directed and randomized checks of seq_subtractor against an arithmetic model
module tb_seq_subtractor;
  localparam int SIZE = 16, CHUNK = 4, N = SIZE / CHUNK;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0, n_err = 0;
  logic [SIZE-1:0] last_res;
  seq_subtractor_if #(.SIZE(SIZE)) bus ();
  seq_subtractor #(.SIZE(SIZE), .CHUNK(CHUNK)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic bin,
                       output logic [SIZE-1:0] r, output logic bo, output logic ov);
    int d, sd;
    d = int'(a) - int'(b) - int'(bin);
    sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
    r = d[SIZE-1:0];
    bo = d < 0;
    ov = sd > 32767 || sd < -32768;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic bin);
    bus.input1 = a;
    bus.input2 = b;
    bus.b_in = bin;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("accept_busy", bus.busy, 1);
    chk("accept_done", bus.done, 0);
  endtask
  task automatic finish_op(input string tag, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic bin);
    logic [SIZE-1:0] r;
    logic bo, ov;
    int lat;
    lat = 0;
    for (int i = 1; i <= N + 3; i++) begin
      step();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    model(a, b, bin, r, bo, ov);
    chk({tag, "_latency"}, lat, N);
    chk({tag, "_result"}, bus.result, r);
    chk({tag, "_b_out"}, bus.b_out, bo);
    chk({tag, "_ovf"}, bus.ovf, ov);
    chk({tag, "_busy_low"}, bus.busy, 0);
    last_res = r;
  endtask
  task automatic do_op(input string tag, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic bin, input bit scramble);
    issue(a, b, bin);
    if (scramble) begin
      bus.input1 = SIZE'($urandom);
      bus.input2 = SIZE'($urandom);
      bus.b_in = 1'($urandom);
    end
    finish_op(tag, a, b, bin);
    step();
    chk({tag, "_done_pulse"}, bus.done, 0);
    chk({tag, "_hold"}, bus.result, last_res);
  endtask
  initial begin
    int dones;
    logic [SIZE-1:0] ra, rb, seen;
    logic rbin;
    bus.start = 1'b0;
    bus.input1 = '0;
    bus.input2 = '0;
    bus.b_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_b_out", bus.b_out, 0);
    chk("rst_ovf", bus.ovf, 0);
    do_op("basic", 16'h1234, 16'h0234, 1'b0, 1'b0);
    do_op("ripple", 16'h1000, 16'h0001, 1'b0, 1'b1);
    do_op("wrap", 16'h0000, 16'h0001, 1'b0, 1'b0);
    do_op("sovf", 16'h8000, 16'h0001, 1'b0, 1'b0);
    do_op("bin", 16'h0005, 16'h0005, 1'b1, 1'b1);
    do_op("sovf_neg", 16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
    chk("sovf_neg_fixed_ovf", bus.ovf, 1);
    // start pulses during RUN must be ignored
    issue(16'h00FF, 16'h000F, 1'b0);
    dones = 0;
    seen = '0;
    for (int i = 1; i <= N + 4; i++) begin
      bus.start = (i == 2 || i == 3);
      bus.input1 = SIZE'($urandom);
      bus.input2 = SIZE'($urandom);
      step();
      bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        seen = bus.result;
        chk("ignore_latency", i, N);
      end
    end
    chk("ignore_dones", dones, 1);
    chk("ignore_result", seen, 16'h00F0);
    // back-to-back: start held through DONE
    bus.input1 = 16'h0010;
    bus.input2 = 16'h0001;
    bus.b_in = 1'b0;
    bus.start = 1'b1;
    step();
    for (int i = 1; i <= N; i++) begin
      step();
      if (i < N) chk("b2b_no_early_done", bus.done, 0);
    end
    chk("b2b_first_done", bus.done, 1);
    chk("b2b_first_result", bus.result, 16'h000F);
    step();
    bus.start = 1'b0;
    chk("b2b_no_gap_busy", bus.busy, 1);
    chk("b2b_no_gap_done", bus.done, 0);
    finish_op("b2b_second", 16'h0010, 16'h0001, 1'b0);
    step();
    // reset aborts a running operation
    issue(16'h4321, 16'h1234, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_b_out", bus.b_out, 0);
    chk("abort_ovf", bus.ovf, 0);
    dones = 0;
    for (int i = 0; i < N + 3; i++) begin
      step();
      if (bus.done) dones++;
    end
    chk("abort_no_done", dones, 0);
    do_op("after_abort", 16'hBEEF, 16'hCAFE, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) begin
      ra = SIZE'($urandom);
      rb = SIZE'($urandom);
      rbin = 1'($urandom);
      if (k % 5 == 0) rb = ra;
      do_op("random", ra, rb, rbin, 1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
